counter_ctrl: RTL and testbench

- Control FSM that sits directly upstream of the 16-bit up/down counter datapath.
- Drives op, c_ld and c_clr to the datapath; consumes its z (count==0) and m (count==max) status flags.
- Converts user start/stop/clear requests plus direction and mode selects into paced count steps. A prescaler sets the count rate.
- Supports one-shot counting (stop at limit) and bounce counting (reverse at limit).

---
 rtl/ctrl_pkg.sv | 20 ++
 rtl/edge_detect.sv | 23 ++
 rtl/counter_ctrl.sv | 147 ++++++++++++++
 tb/tb_counter_ctrl.sv | 221 ++++++++++++++++++++++
 4 files changed

// File: rtl/ctrl_pkg.sv
// Shared definitions for the counter control FSM and the up/down counter datapath.
// Pure declarations: no logic, no latency, no flow control.
package ctrl_pkg;

    localparam int STATE_W = 3;

    typedef enum logic [STATE_W-1:0] {
        ST_IDLE  = 3'd0,
        ST_CLEAR = 3'd1,
        ST_UP    = 3'd2,
        ST_DOWN  = 3'd3,
        ST_PAUSE = 3'd4,
        ST_DONE  = 3'd5
    } state_t;

    // Datapath adder/subtractor select, shared with the counter datapath.
    localparam logic OP_ADD = 1'b0;
    localparam logic OP_SUB = 1'b1;

endpackage

// File: rtl/edge_detect.sv
// Single-bit rising-edge detector for level request inputs.
// Latency: combinational pulse in the cycle the level first reads high.
// Backpressure: none; a held level yields exactly one pulse.
module edge_detect (
    input  logic clk,
    input  logic rst_n,
    input  logic din,
    output logic rise
);

    logic din_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            din_q <= 1'b0;
        end else begin
            din_q <= din;
        end
    end

    assign rise = din & ~din_q;

endmodule

// File: rtl/counter_ctrl.sv
// Control FSM pacing a 16-bit up/down counter datapath (one-shot or bounce counting).
// Latency: start edge in cycle n -> running at n+1, first c_ld at n+TICK_DIV.
// Backpressure: none; datapath strobes are single-cycle and unconditionally accepted.
module counter_ctrl
    import ctrl_pkg::*;
#(
    parameter int TICK_DIV = 1,
    parameter int TICK_W   = 16
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    input  logic               stop,
    input  logic               clr,
    input  logic               dir,
    input  logic               mode,
    input  logic               z,
    input  logic               m,
    output logic               op,
    output logic               c_ld,
    output logic               c_clr,
    output logic               running,
    output logic               done,
    output logic [STATE_W-1:0] state_o
);

    localparam logic [TICK_W-1:0] TICK_LAST = TICK_W'(TICK_DIV - 1);

    state_t              state_q, state_d;
    logic [TICK_W-1:0]   presc_q, presc_d;
    logic                dir_q, dir_d;
    logic                start_e, stop_e;
    logic                in_run;
    logic                tick;

    edge_detect u_start_edge (
        .clk   (clk),
        .rst_n (rst),
        .din   (start),
        .rise  (start_e)
    );

    edge_detect u_stop_edge (
        .clk   (clk),
        .rst_n (rst),
        .din   (stop),
        .rise  (stop_e)
    );

    assign in_run = (state_q == ST_UP) || (state_q == ST_DOWN);
    assign tick   = in_run && (presc_q == TICK_LAST);

    always_comb begin
        state_d = state_q;
        dir_d   = dir_q;
        op      = dir_q;
        c_ld    = 1'b0;
        c_clr   = 1'b0;
        running = 1'b0;
        done    = 1'b0;

        case (state_q)
            ST_IDLE, ST_DONE: begin
                done = (state_q == ST_DONE);
                if (start_e && !stop_e) begin
                    dir_d   = dir;
                    state_d = dir ? ST_DOWN : ST_UP;
                end
            end
            ST_CLEAR: begin
                c_clr   = 1'b1;
                state_d = ST_IDLE;
            end
            ST_UP: begin
                op      = OP_ADD;
                running = 1'b1;
                // Limit is checked before loading so the count never wraps.
                if (stop_e) begin
                    state_d = ST_PAUSE;
                end else if (tick) begin
                    if (!m) begin
                        c_ld = 1'b1;
                    end else if (mode) begin
                        state_d = ST_DOWN;
                        dir_d   = 1'b1;
                    end else begin
                        state_d = ST_DONE;
                    end
                end
            end
            ST_DOWN: begin
                op      = OP_SUB;
                running = 1'b1;
                if (stop_e) begin
                    state_d = ST_PAUSE;
                end else if (tick) begin
                    if (!z) begin
                        c_ld = 1'b1;
                    end else if (mode) begin
                        state_d = ST_UP;
                        dir_d   = 1'b0;
                    end else begin
                        state_d = ST_DONE;
                    end
                end
            end
            ST_PAUSE: begin
                if (start_e && !stop_e) begin
                    state_d = dir_q ? ST_DOWN : ST_UP;
                end
            end
            default: begin
                state_d = ST_CLEAR;
            end
        endcase

        // Clear request overrides every other event, including a pending load.
        if (clr) begin
            state_d = ST_CLEAR;
            dir_d   = dir_q;
            c_ld    = 1'b0;
        end
    end

    // Prescaler restarts on any state change so each entry to UP/DOWN gets a full period.
    always_comb begin
        presc_d = '0;
        if (in_run && (state_d == state_q) && !tick) begin
            presc_d = presc_q + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= ST_CLEAR;
            presc_q <= '0;
            dir_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            presc_q <= presc_d;
            dir_q   <= dir_d;
        end
    end

    assign state_o = state_q;

endmodule

// File: tb/tb_counter_ctrl.sv
// Bench for counter_ctrl: TICK_DIV=1 and TICK_DIV=4 instances, each driving its own counter datapath.
// Expected counts come from arithmetic on elapsed run cycles (cycles / TICK_DIV), capped by the limits.
module tb_counter_ctrl;
    import ctrl_pkg::*;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    logic [1:0] start_v = '0;
    logic [1:0] stop_v  = '0;
    logic [1:0] clr_v   = '0;
    logic [1:0] dir_v   = '0;
    logic [1:0] mode_v  = '0;
    logic [1:0] op_v, ld_v, cclr_v, run_v, done_v, z_v, m_v;
    logic [2:0] st_v [2];
    logic [15:0] cnt [2];

    int checks = 0;
    int errors = 0;

    counter_ctrl #(.TICK_DIV(1), .TICK_W(16)) dut1 (
        .clk(clk), .rst(rst_n), .start(start_v[0]), .stop(stop_v[0]), .clr(clr_v[0]),
        .dir(dir_v[0]), .mode(mode_v[0]), .z(z_v[0]), .m(m_v[0]), .op(op_v[0]),
        .c_ld(ld_v[0]), .c_clr(cclr_v[0]), .running(run_v[0]), .done(done_v[0]),
        .state_o(st_v[0])
    );

    counter_ctrl #(.TICK_DIV(4), .TICK_W(16)) dut4 (
        .clk(clk), .rst(rst_n), .start(start_v[1]), .stop(stop_v[1]), .clr(clr_v[1]),
        .dir(dir_v[1]), .mode(mode_v[1]), .z(z_v[1]), .m(m_v[1]), .op(op_v[1]),
        .c_ld(ld_v[1]), .c_clr(cclr_v[1]), .running(run_v[1]), .done(done_v[1]),
        .state_o(st_v[1])
    );

    // Counter datapath environment for both instances.
    always @(posedge clk) begin
        for (int k = 0; k < 2; k++) begin
            if (cclr_v[k]) begin
                cnt[k] <= 16'd0;
            end else if (ld_v[k]) begin
                cnt[k] <= op_v[k] ? cnt[k] - 16'd1 : cnt[k] + 16'd1;
            end
        end
    end

    assign z_v = {cnt[1] == 16'd0, cnt[0] == 16'd0};
    assign m_v = {cnt[1] == 16'hFFFF, cnt[0] == 16'hFFFF};

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic pulse_start(input int k);
        start_v[k] = 1'b1;
        step(1);
        start_v[k] = 1'b0;
    endtask

    task automatic pulse_stop(input int k);
        stop_v[k] = 1'b1;
        step(1);
        stop_v[k] = 1'b0;
    endtask

    initial begin
        int r;
        int exp4;

        // Reset values
        step(2);
        chk("rst_state", 32'(st_v[0]), 32'(ST_CLEAR));
        chk("rst_c_clr", 32'(cclr_v[0]), 32'd1);
        chk("rst_c_ld", 32'(ld_v[0]), 32'd0);
        chk("rst_op", 32'(op_v[0]), 32'd0);
        chk("rst_running", 32'(run_v[0]), 32'd0);
        chk("rst_done", 32'(done_v[0]), 32'd0);
        rst_n = 1'b1;
        chk("rel_c_clr", 32'(cclr_v[0]), 32'd1);
        step(1);
        chk("rel_idle", 32'(st_v[0]), 32'(ST_IDLE));
        chk("rel_c_clr_low", 32'(cclr_v[0]), 32'd0);
        chk("rel_c_ld_low", 32'(ld_v[0]), 32'd0);
        chk("rel_cnt", 32'(cnt[0]), 32'd0);
        chk("rel_idle4", 32'(st_v[1]), 32'(ST_IDLE));

        // One-shot full up-count with TICK_DIV=1
        dir_v[0]  = 1'b0;
        mode_v[0] = 1'b0;
        pulse_start(0);
        chk("up_state", 32'(st_v[0]), 32'(ST_UP));
        chk("up_c_ld", 32'(ld_v[0]), 32'd1);
        chk("up_op", 32'(op_v[0]), 32'd0);
        r = int'($urandom_range(30000, 1));
        step(r);
        chk("up_mid_cnt", 32'(cnt[0]), 32'(r));
        chk("up_mid_running", 32'(run_v[0]), 32'd1);
        step(65535 - r);
        chk("up_max_cnt", 32'(cnt[0]), 32'hFFFF);
        chk("up_max_no_ld", 32'(ld_v[0]), 32'd0);
        step(1);
        chk("done_flag", 32'(done_v[0]), 32'd1);
        chk("done_state", 32'(st_v[0]), 32'(ST_DONE));
        step(3);
        chk("done_hold_cnt", 32'(cnt[0]), 32'hFFFF);
        chk("done_no_ld", 32'(ld_v[0]), 32'd0);

        // Clear, then bounce from zero counting down
        clr_v[0] = 1'b1;
        step(1);
        clr_v[0] = 1'b0;
        chk("clr_state", 32'(st_v[0]), 32'(ST_CLEAR));
        chk("clr_strobe", 32'(cclr_v[0]), 32'd1);
        step(1);
        chk("clr_idle", 32'(st_v[0]), 32'(ST_IDLE));
        chk("clr_cnt", 32'(cnt[0]), 32'd0);
        dir_v[0]  = 1'b1;
        mode_v[0] = 1'b1;
        pulse_start(0);
        dir_v[0] = 1'b0;
        chk("bnc_down", 32'(st_v[0]), 32'(ST_DOWN));
        chk("bnc_op_sub", 32'(op_v[0]), 32'd1);
        chk("bnc_no_ld", 32'(ld_v[0]), 32'd0);
        step(1);
        chk("bnc_up", 32'(st_v[0]), 32'(ST_UP));
        chk("bnc_cnt0", 32'(cnt[0]), 32'd0);
        chk("bnc_op_add", 32'(op_v[0]), 32'd0);
        step(2);
        chk("bnc_cnt2", 32'(cnt[0]), 32'd2);

        // clr, stop and start rising together at count 5
        step(3);
        chk("pri_cnt5", 32'(cnt[0]), 32'd5);
        clr_v[0]   = 1'b1;
        stop_v[0]  = 1'b1;
        start_v[0] = 1'b1;
        step(1);
        clr_v[0]   = 1'b0;
        stop_v[0]  = 1'b0;
        start_v[0] = 1'b0;
        chk("pri_state", 32'(st_v[0]), 32'(ST_CLEAR));
        chk("pri_c_clr", 32'(cclr_v[0]), 32'd1);
        chk("pri_cnt_held", 32'(cnt[0]), 32'd5);
        step(1);
        chk("pri_idle", 32'(st_v[0]), 32'(ST_IDLE));
        chk("pri_cnt0", 32'(cnt[0]), 32'd0);

        // Held start gives one event; async reset mid-count
        mode_v[0]  = 1'b0;
        start_v[0] = 1'b1;
        step(1);
        chk("hold_up", 32'(st_v[0]), 32'(ST_UP));
        step(19);
        chk("hold_still_up", 32'(st_v[0]), 32'(ST_UP));
        chk("hold_cnt", 32'(cnt[0]), 32'd19);
        start_v[0] = 1'b0;
        #3 rst_n = 1'b0;
        #1;
        chk("arst_state", 32'(st_v[0]), 32'(ST_CLEAR));
        chk("arst_c_clr", 32'(cclr_v[0]), 32'd1);
        chk("arst_running", 32'(run_v[0]), 32'd0);
        step(1);
        rst_n = 1'b1;
        chk("arst_rel_c_clr", 32'(cclr_v[0]), 32'd1);
        step(1);
        chk("arst_idle", 32'(st_v[0]), 32'(ST_IDLE));
        chk("arst_cnt", 32'(cnt[0]), 32'd0);

        // TICK_DIV=4 pacing, pause and resume
        dir_v[1]  = 1'b0;
        mode_v[1] = 1'b0;
        pulse_start(1);
        chk("d4_up", 32'(st_v[1]), 32'(ST_UP));
        for (int i = 0; i < 10; i++) begin
            chk("d4_pace", 32'(ld_v[1]), 32'(i % 4 == 3));
            step(1);
        end
        pulse_stop(1);
        chk("d4_pause", 32'(st_v[1]), 32'(ST_PAUSE));
        chk("d4_cnt2", 32'(cnt[1]), 32'd2);
        chk("d4_pause_op", 32'(op_v[1]), 32'd0);
        step(3);
        chk("d4_pause_hold", 32'(cnt[1]), 32'd2);
        dir_v[1] = 1'b1;
        pulse_start(1);
        chk("d4_resume_up", 32'(st_v[1]), 32'(ST_UP));
        for (int i = 0; i < 4; i++) begin
            chk("d4_resume_pace", 32'(ld_v[1]), 32'(i == 3));
            step(1);
        end
        pulse_stop(1);
        exp4 = 3;
        chk("d4_cnt3", 32'(cnt[1]), 32'(exp4));

        // Random run lengths between pauses; dir changes must be ignored on resume
        for (int rnd = 0; rnd < 4; rnd++) begin
            dir_v[1] = 1'($urandom_range(1, 0));
            r = int'($urandom_range(40, 1));
            pulse_start(1);
            chk("d4_rnd_up", 32'(st_v[1]), 32'(ST_UP));
            step(r);
            pulse_stop(1);
            exp4 = exp4 + r / 4;
            chk("d4_rnd_pause", 32'(st_v[1]), 32'(ST_PAUSE));
            chk("d4_rnd_cnt", 32'(cnt[1]), 32'(exp4));
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
